alarm_arm_controller: RTL and testbench
=======================================

ALARM_ARM_CONTROLLER -- requirements
Module: alarm_arm_controller

Interface
REQ-001 Parameter EXIT_DLY, default 10, SHALL be the exit delay in ticks (legal 1..63).
REQ-002 Parameter ENTRY_DLY, default 8, SHALL be the entry delay in ticks (legal 1..63).
REQ-003 Parameter SIREN_TIME, default 30, SHALL be the siren duration in ticks (legal 1..63).
REQ-004 Parameter USER_CODE, default 4'hA, SHALL be the disarm code.
REQ-005 Parameter MAX_FAIL, default 3, SHALL be the wrong-code limit (legal 1..3).
REQ-006 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-007 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-008 tick  input  1  SHALL be a one-cycle timebase strobe (e.g. 1 Hz prescale).
REQ-009 arm_req  input  1  SHALL be a one-cycle arm request pulse.
REQ-010 code_valid  input  1  SHALL qualify code_in for one cycle.
REQ-011 code_in  input  4  SHALL be the keypad code entered.
REQ-012 trigger  input  1  SHALL be the intrusion-detector output (level).
REQ-013 panic  input  1  SHALL be the panic button (level).
REQ-014 alarm_enable  output  1  SHALL drive the detector's alarm switch; high in ARMED and ENTRY.
REQ-015 siren  output  1  SHALL be high only in ALARM.
REQ-016 state  output  3  SHALL be the state code: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4.
REQ-017 remaining  output  6  SHALL be the current timer value; 0 in DISARMED and ARMED.
REQ-018 fail_cnt  output  2  SHALL be the count of consecutive wrong codes.

Function
REQ-019 All outputs SHALL be decoded from registers only; no combinational input-to-output path.
REQ-020 The timer SHALL load the state's delay on entry to EXIT, ENTRY or ALARM and decrement by 1 on each cycle with tick=1.
REQ-021 A timed state SHALL exit on the edge where tick=1 and timer==1, i.e. exactly N ticks after entry.
REQ-022 DISARMED: arm_req=1 -> EXIT; code_valid ignored; trigger ignored.
REQ-023 EXIT: timer expiry -> ARMED; trigger ignored.
REQ-024 ARMED: trigger=1 -> ENTRY.
REQ-025 ENTRY: timer expiry -> ALARM.
REQ-026 ALARM: timer expiry -> ARMED, siren off, timer 0 (auto re-arm).
REQ-027 In any state except DISARMED, code_valid with code_in==USER_CODE -> DISARMED and fail_cnt cleared.
REQ-028 In any state except DISARMED, code_valid with wrong code SHALL increment fail_cnt.
REQ-029 When an increment makes fail_cnt reach MAX_FAIL -> ALARM (timer reloaded), fail_cnt cleared.
REQ-030 panic=1 in any state -> ALARM with timer reloaded to SIREN_TIME, including while already in ALARM.
REQ-031 Priority, highest first: panic, correct code, wrong-code limit, timer expiry/trigger, arm_req.
REQ-032 Simultaneous correct code and tick at timer==1 SHALL disarm; no timed transition occurs.
REQ-033 arm_req outside DISARMED SHALL be ignored.
REQ-034 fail_cnt SHALL clear on entry to DISARMED and SHALL hold otherwise.

Reset
REQ-035 rst_n low SHALL immediately force state=DISARMED, timer=0, fail_cnt=0, siren=0, alarm_enable=0, remaining=0.
REQ-036 Reset asserted mid-ALARM or mid-delay SHALL abort the operation; no pending transition survives.
REQ-037 After rst_n rises, the first input sampling SHALL occur on the next rising clk edge.

Verification
REQ-038 Reset, then arm_req pulse, then 10 ticks -> state 1 for 10 ticks, remaining 10..1, then state=2, alarm_enable=1.
REQ-039 ARMED, trigger=1, then 8 ticks with no code -> state=3 after 1 cycle, then state=4, siren=1; 30 ticks later state=2, siren=0.
REQ-040 ENTRY, code 4'h3 three times -> fail_cnt 1, 2, then state=4 with fail_cnt=0; then code 4'hA -> state=0, siren=0.
REQ-041 DISARMED, panic=1 for one cycle -> state=4, remaining=30; panic repeated at remaining=5 -> remaining reloads to 30.
REQ-042 ENTRY with remaining=1, tick and correct code in the same cycle -> state=0, siren never asserted.
REQ-043 rst_n driven low mid-ALARM between clock edges -> outputs reset before the next edge; trigger=1 after release keeps state=0.

Source files
------------

// File: rtl/alarm_arm_if.sv
// ---------------------------------------------------------------------------
// alarm_arm_if
// Signal bundle between the alarm keypad/sensor side and the arming
// controller.
//
// Inputs to the controller (driven by master):
//   tick        one-cycle timebase strobe
//   arm_req     one-cycle arm request pulse
//   code_valid  qualifies code_in for one cycle
//   code_in     4-bit keypad code
//   trigger     intrusion detector output (level)
//   panic       panic button (level)
// Outputs from the controller (driven by slave):
//   alarm_enable  detector alarm switch, high in ARMED and ENTRY
//   siren         high only in ALARM
//   state         state code (DISARMED=0 EXIT=1 ARMED=2 ENTRY=3 ALARM=4)
//   remaining     current timer value, 0 in DISARMED and ARMED
//   fail_cnt      consecutive wrong-code count
// ---------------------------------------------------------------------------
interface alarm_arm_if;
    logic       tick;
    logic       arm_req;
    logic       code_valid;
    logic [3:0] code_in;
    logic       trigger;
    logic       panic;

    logic       alarm_enable;
    logic       siren;
    logic [2:0] state;
    logic [5:0] remaining;
    logic [1:0] fail_cnt;

    modport master (
        output tick, arm_req, code_valid, code_in, trigger, panic,
        input  alarm_enable, siren, state, remaining, fail_cnt
    );

    modport slave (
        input  tick, arm_req, code_valid, code_in, trigger, panic,
        output alarm_enable, siren, state, remaining, fail_cnt
    );
endinterface

// File: rtl/alarm_arm_controller.sv
// ---------------------------------------------------------------------------
// alarm_arm_controller
// Intrusion-alarm arming state machine with exit delay, entry delay, timed
// siren with automatic re-arm, keypad disarm and a wrong-code lockout that
// raises the alarm.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    alarm_arm_if.slave (tick, arm_req, code_valid, code_in, trigger,
//          panic in; alarm_enable, siren, state, remaining, fail_cnt out)
//
// Parameters: EXIT_DLY, ENTRY_DLY, SIREN_TIME in ticks (1..63),
//             USER_CODE disarm code, MAX_FAIL wrong-code limit (1..3).
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module alarm_arm_controller #(
    parameter int          EXIT_DLY   = 10,
    parameter int          ENTRY_DLY  = 8,
    parameter int          SIREN_TIME = 30,
    parameter logic [3:0]  USER_CODE  = 4'hA,
    parameter int          MAX_FAIL   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alarm_arm_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    localparam logic [5:0] EXIT_T   = 6'(EXIT_DLY);
    localparam logic [5:0] ENTRY_T  = 6'(ENTRY_DLY);
    localparam logic [5:0] SIREN_T  = 6'(SIREN_TIME);
    localparam logic [1:0] FAIL_LIM = 2'(MAX_FAIL);

    state_t     state_q, state_d;
    logic [5:0] timer_q, timer_d;
    logic [1:0] fail_q,  fail_d;

    logic timed;
    logic expire;
    logic code_ok;
    logic code_bad;
    logic limit_hit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DISARMED;
            timer_q <= 6'd0;
            fail_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
        end
    end

    // Next-state logic, evaluated in priority order:
    // panic, correct code, wrong-code limit, timer expiry/trigger, arm_req.
    always_comb begin
        timed     = (state_q == ST_EXIT) || (state_q == ST_ENTRY) ||
                    (state_q == ST_ALARM);
        expire    = timed && bus.tick && (timer_q == 6'd1);
        code_ok   = (state_q != ST_DISARMED) && bus.code_valid &&
                    (bus.code_in == USER_CODE);
        code_bad  = (state_q != ST_DISARMED) && bus.code_valid &&
                    (bus.code_in != USER_CODE);
        limit_hit = code_bad && ((fail_q + 2'd1) == FAIL_LIM);

        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;

        if (bus.panic) begin
            // Re-entering ALARM while already there restarts the siren time.
            state_d = ST_ALARM;
            timer_d = SIREN_T;
        end else if (code_ok) begin
            state_d = ST_DISARMED;
            timer_d = 6'd0;
            fail_d  = 2'd0;
        end else if (limit_hit) begin
            state_d = ST_ALARM;
            timer_d = SIREN_T;
            fail_d  = 2'd0;
        end else begin
            // A wrong code below the limit only counts; timed behaviour
            // continues in the same cycle.
            if (code_bad) begin
                fail_d = fail_q + 2'd1;
            end
            if (timed && bus.tick) begin
                timer_d = timer_q - 6'd1;
            end
            case (state_q)
                ST_DISARMED: begin
                    if (bus.arm_req) begin
                        state_d = ST_EXIT;
                        timer_d = EXIT_T;
                    end
                end
                ST_EXIT: begin
                    if (expire) begin
                        state_d = ST_ARMED;
                        timer_d = 6'd0;
                    end
                end
                ST_ARMED: begin
                    if (bus.trigger) begin
                        state_d = ST_ENTRY;
                        timer_d = ENTRY_T;
                    end
                end
                ST_ENTRY: begin
                    if (expire) begin
                        state_d = ST_ALARM;
                        timer_d = SIREN_T;
                    end
                end
                ST_ALARM: begin
                    // Siren timeout re-arms rather than disarming.
                    if (expire) begin
                        state_d = ST_ARMED;
                        timer_d = 6'd0;
                    end
                end
                default: begin
                    state_d = ST_DISARMED;
                    timer_d = 6'd0;
                    fail_d  = 2'd0;
                end
            endcase
        end
    end

    // Output decode, registers only
    always_comb begin
        bus.state        = state_q;
        bus.alarm_enable = (state_q == ST_ARMED) || (state_q == ST_ENTRY);
        bus.siren        = (state_q == ST_ALARM);
        bus.fail_cnt     = fail_q;
        if ((state_q == ST_EXIT) || (state_q == ST_ENTRY) ||
            (state_q == ST_ALARM)) begin
            bus.remaining = timer_q;
        end else begin
            bus.remaining = 6'd0;
        end
    end

endmodule

// File: tb/tb_alarm_arm_controller.sv
module tb_alarm_arm_controller;

    localparam int         EXIT_DLY   = 10;
    localparam int         ENTRY_DLY  = 8;
    localparam int         SIREN_TIME = 30;
    localparam logic [3:0] USER_CODE  = 4'hA;
    localparam int         MAX_FAIL   = 3;

    logic clk;
    logic rst_n;

    alarm_arm_if bus ();

    alarm_arm_controller #(
        .EXIT_DLY   (EXIT_DLY),
        .ENTRY_DLY  (ENTRY_DLY),
        .SIREN_TIME (SIREN_TIME),
        .USER_CODE  (USER_CODE),
        .MAX_FAIL   (MAX_FAIL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: system mode, countdown of ticks left, wrong-code tally
    int m_mode;
    int m_left;
    int m_fails;
    int siren_seen;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_left  = 0;
        m_fails = 0;
    endtask

    // Apply the behavioural rules for one clock edge using current inputs.
    task automatic model_edge();
        bit in_delay;
        bit good;
        bit bad;
        in_delay = (m_mode == 1) || (m_mode == 3) || (m_mode == 4);
        good = (m_mode != 0) && bus.code_valid && (bus.code_in == USER_CODE);
        bad  = (m_mode != 0) && bus.code_valid && (bus.code_in != USER_CODE);
        if (bus.panic) begin
            m_mode = 4; m_left = SIREN_TIME;
        end else if (good) begin
            m_mode = 0; m_left = 0; m_fails = 0;
        end else if (bad && (m_fails + 1 == MAX_FAIL)) begin
            m_mode = 4; m_left = SIREN_TIME; m_fails = 0;
        end else begin
            if (bad) m_fails = m_fails + 1;
            if (in_delay && bus.tick) begin
                if (m_left == 1) begin
                    // delay finished: EXIT->ARMED, ENTRY->ALARM, ALARM->ARMED
                    if (m_mode == 3) begin
                        m_mode = 4; m_left = SIREN_TIME;
                    end else begin
                        m_mode = 2; m_left = 0;
                    end
                end else begin
                    m_left = m_left - 1;
                end
            end else if (m_mode == 0 && bus.arm_req) begin
                m_mode = 1; m_left = EXIT_DLY;
            end else if (m_mode == 2 && bus.trigger) begin
                m_mode = 3; m_left = ENTRY_DLY;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, int'(bus.state), m_mode);
        check({tag, ".remaining"}, int'(bus.remaining), m_left);
        check({tag, ".fail_cnt"}, int'(bus.fail_cnt), m_fails);
        check({tag, ".siren"}, int'(bus.siren), (m_mode == 4) ? 1 : 0);
        check({tag, ".alarm_enable"}, int'(bus.alarm_enable),
              (m_mode == 2 || m_mode == 3) ? 1 : 0);
        if (bus.siren === 1'b1) siren_seen++;
    endtask

    // Drive inputs for one cycle, clock it, update model, check 1 time unit
    // after the edge.
    task automatic cyc(input string tag, input logic t, input logic a,
                       input logic cv, input logic [3:0] ci,
                       input logic trg, input logic pn);
        bus.tick       = t;
        bus.arm_req    = a;
        bus.code_valid = cv;
        bus.code_in    = ci;
        bus.trigger    = trg;
        bus.panic      = pn;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic tk(input string tag);
        cyc(tag, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.tick       = 1'b0;
        bus.arm_req    = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_in    = 4'h0;
        bus.trigger    = 1'b0;
        bus.panic      = 1'b0;
        siren_seen     = 0;
        model_reset();

        // Reset state
        #1;
        check_all("reset");
        idle("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset");

        // Codes are ignored while disarmed
        cyc("dis_code", 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
        check("dis_code_fail", int'(bus.fail_cnt), 0);

        // Arm, exit delay of 10 ticks, ticks on alternate cycles
        cyc("arm", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check("exit_state", int'(bus.state), 1);
        for (int i = 0; i < EXIT_DLY; i++) begin
            check("exit_rem", int'(bus.remaining), EXIT_DLY - i);
            cyc("exit_trg", 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
            tk("exit_tick");
        end
        check("armed_state", int'(bus.state), 2);
        check("armed_en", int'(bus.alarm_enable), 1);

        // Trigger, entry delay, siren, auto re-arm
        cyc("trigger", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("entry_state", int'(bus.state), 3);
        check("entry_rem", int'(bus.remaining), ENTRY_DLY);
        for (int i = 0; i < ENTRY_DLY; i++) tk("entry_tick");
        check("alarm_state", int'(bus.state), 4);
        check("alarm_siren", int'(bus.siren), 1);
        check("alarm_rem", int'(bus.remaining), SIREN_TIME);
        for (int i = 0; i < SIREN_TIME; i++) tk("siren_tick");
        check("rearm_state", int'(bus.state), 2);
        check("rearm_siren", int'(bus.siren), 0);
        check("rearm_rem", int'(bus.remaining), 0);

        // Wrong code lockout then correct code
        cyc("trigger2", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        cyc("bad1", 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        check("bad1_fail", int'(bus.fail_cnt), 1);
        cyc("bad2", 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        check("bad2_fail", int'(bus.fail_cnt), 2);
        cyc("bad3", 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        check("bad3_state", int'(bus.state), 4);
        check("bad3_fail", int'(bus.fail_cnt), 0);
        cyc("good", 1'b0, 1'b0, 1'b1, USER_CODE, 1'b0, 1'b0);
        check("good_state", int'(bus.state), 0);
        check("good_siren", int'(bus.siren), 0);

        // Panic from DISARMED, re-panic reloads timer
        cyc("panic", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("panic_state", int'(bus.state), 4);
        check("panic_rem", int'(bus.remaining), SIREN_TIME);
        for (int i = 0; i < SIREN_TIME - 5; i++) tk("panic_tick");
        check("panic_rem5", int'(bus.remaining), 5);
        cyc("repanic", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("repanic_rem", int'(bus.remaining), SIREN_TIME);
        cyc("disarm2", 1'b0, 1'b0, 1'b1, USER_CODE, 1'b0, 1'b0);

        // Correct code wins over expiry at remaining==1
        cyc("arm3", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < EXIT_DLY; i++) tk("exit3_tick");
        cyc("trigger3", 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < ENTRY_DLY - 1; i++) tk("entry3_tick");
        check("entry3_rem1", int'(bus.remaining), 1);
        siren_seen = 0;
        cyc("code_at_expiry", 1'b1, 1'b0, 1'b1, USER_CODE, 1'b0, 1'b0);
        idle("after_expiry_code");
        check("expiry_code_state", int'(bus.state), 0);
        check("expiry_code_nosiren", siren_seen, 0);

        // Asynchronous reset in the middle of ALARM
        cyc("panic4", 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tk("alarm4_tick");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset_state", int'(bus.state), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("post_rst_trg", 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check("post_rst_state", int'(bus.state), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_tick, r_arm, r_cv, r_trg, r_pn;
            logic [3:0] r_code;
            r_tick = ($urandom_range(0, 2) == 0);
            r_arm  = ($urandom_range(0, 7) == 0);
            r_cv   = ($urandom_range(0, 9) == 0);
            r_trg  = ($urandom_range(0, 5) == 0);
            r_pn   = ($urandom_range(0, 99) == 0);
            r_code = ($urandom_range(0, 2) == 0) ? USER_CODE : 4'($urandom_range(0, 15));
            cyc("rand", r_tick, r_arm, r_cv, r_code, r_trg, r_pn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
